// File: rtl/tl_cache_pipe_reg.sv
// Elastic TL -> C stage pipeline register with optional two-entry skid buffer,
// kill-based flush, saturating hit/miss counters and a sticky hit&miss error flag.
module tl_cache_pipe_reg #(
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned WAY_W   = 2,
    parameter int unsigned SKID_EN = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              kill_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] tl_addr_i,
    input  logic              tl_rqst_byte_i,
    input  logic [WAY_W-1:0]  tl_hit_way_i,
    input  logic [WAY_W-1:0]  tl_lru_way_i,
    input  logic              tl_hit_i,
    input  logic              tl_miss_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] c_addr_o,
    output logic              c_rqst_byte_o,
    output logic [WAY_W-1:0]  c_hit_way_o,
    output logic [WAY_W-1:0]  c_lru_way_o,
    output logic              c_hit_o,
    output logic              c_miss_o,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o,
    output logic              err_o
);

    localparam int unsigned PW = ADDR_W + 2 * WAY_W + 3;

    logic [PW-1:0]    in_pld;
    logic [PW-1:0]    main_q, main_d;
    logic [PW-1:0]    skid_q, skid_d;
    logic [PW-1:0]    main_gated;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             err_q, err_d;
    logic             in_xfer, out_xfer;

    assign in_pld = {tl_addr_i, tl_rqst_byte_i, tl_hit_way_i, tl_lru_way_i, tl_hit_i, tl_miss_i};

    // Skid variant keeps in_ready_o purely registered; the bare variant trades that for one less entry.
    always_comb begin
        if (SKID_EN != 0) begin
            in_ready_o = ~skid_valid_q;
        end else begin
            in_ready_o = ~kill_i & (~main_valid_q | out_ready_i);
        end
    end

    assign out_valid_o = main_valid_q;
    assign in_xfer     = in_valid_i & in_ready_o;
    assign out_xfer    = out_valid_o & out_ready_i;

    assign main_gated = main_valid_q ? main_q : '0;
    assign {c_addr_o, c_rqst_byte_o, c_hit_way_o, c_lru_way_o, c_hit_o, c_miss_o} = main_gated;

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
    assign err_o      = err_q;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (kill_i) begin
            main_d       = '0;
            main_valid_d = 1'b0;
            skid_d       = '0;
            skid_valid_d = 1'b0;
        end else begin
            if (out_xfer) begin
                if (skid_valid_q) begin
                    main_d       = skid_q;
                    main_valid_d = 1'b1;
                    skid_valid_d = 1'b0;
                end else begin
                    main_valid_d = 1'b0;
                end
            end
            // in_xfer cannot coincide with a skid->main move since in_ready_o is low then.
            if (in_xfer) begin
                if (!main_valid_q || (out_xfer && !skid_valid_q)) begin
                    main_d       = in_pld;
                    main_valid_d = 1'b1;
                end else begin
                    skid_d       = in_pld;
                    skid_valid_d = 1'b1;
                end
            end
        end
        if (SKID_EN == 0) begin
            skid_d       = '0;
            skid_valid_d = 1'b0;
        end
    end

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        err_d      = err_q;
        if (!kill_i) begin
            if (out_xfer && c_hit_o && (hit_cnt_q != '1)) begin
                hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end
            if (out_xfer && c_miss_o && (miss_cnt_q != '1)) begin
                miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
            if (in_xfer && tl_hit_i && tl_miss_i) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_tl_cache_pipe_reg.sv
// Directed bench: three instances (skid, 2-bit counters, no skid) share one stimulus stream;
// each section resets and checks the instance it targets.
module tb_tl_cache_pipe_reg;

    logic        clk;
    logic        rst;
    logic        kill;
    logic        in_valid;
    logic        out_ready;
    logic [19:0] addr;
    logic        rqst_byte;
    logic [1:0]  hit_way;
    logic [1:0]  lru_way;
    logic        hit;
    logic        miss;

    logic        a_in_ready, a_out_valid, a_byte, a_hit, a_miss, a_err;
    logic [19:0] a_addr;
    logic [1:0]  a_hit_way, a_lru_way;
    logic [15:0] a_hit_cnt, a_miss_cnt;

    logic        s_in_ready, s_out_valid, s_byte, s_hit, s_miss, s_err;
    logic [19:0] s_addr;
    logic [1:0]  s_hit_way, s_lru_way;
    logic [1:0]  s_hit_cnt, s_miss_cnt;

    logic        n_in_ready, n_out_valid, n_byte, n_hit, n_miss, n_err;
    logic [19:0] n_addr;
    logic [1:0]  n_hit_way, n_lru_way;
    logic [15:0] n_hit_cnt, n_miss_cnt;

    int unsigned n_checks;
    int unsigned n_fail;

    tl_cache_pipe_reg #(.ADDR_W(20), .WAY_W(2), .SKID_EN(1), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .kill_i(kill),
        .in_valid_i(in_valid), .in_ready_o(a_in_ready),
        .tl_addr_i(addr), .tl_rqst_byte_i(rqst_byte), .tl_hit_way_i(hit_way),
        .tl_lru_way_i(lru_way), .tl_hit_i(hit), .tl_miss_i(miss),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready),
        .c_addr_o(a_addr), .c_rqst_byte_o(a_byte), .c_hit_way_o(a_hit_way),
        .c_lru_way_o(a_lru_way), .c_hit_o(a_hit), .c_miss_o(a_miss),
        .hit_cnt_o(a_hit_cnt), .miss_cnt_o(a_miss_cnt), .err_o(a_err)
    );

    tl_cache_pipe_reg #(.ADDR_W(20), .WAY_W(2), .SKID_EN(1), .CNT_W(2)) u_sat (
        .clk_i(clk), .rst_i(rst), .kill_i(kill),
        .in_valid_i(in_valid), .in_ready_o(s_in_ready),
        .tl_addr_i(addr), .tl_rqst_byte_i(rqst_byte), .tl_hit_way_i(hit_way),
        .tl_lru_way_i(lru_way), .tl_hit_i(hit), .tl_miss_i(miss),
        .out_valid_o(s_out_valid), .out_ready_i(out_ready),
        .c_addr_o(s_addr), .c_rqst_byte_o(s_byte), .c_hit_way_o(s_hit_way),
        .c_lru_way_o(s_lru_way), .c_hit_o(s_hit), .c_miss_o(s_miss),
        .hit_cnt_o(s_hit_cnt), .miss_cnt_o(s_miss_cnt), .err_o(s_err)
    );

    tl_cache_pipe_reg #(.ADDR_W(20), .WAY_W(2), .SKID_EN(0), .CNT_W(16)) u_ns (
        .clk_i(clk), .rst_i(rst), .kill_i(kill),
        .in_valid_i(in_valid), .in_ready_o(n_in_ready),
        .tl_addr_i(addr), .tl_rqst_byte_i(rqst_byte), .tl_hit_way_i(hit_way),
        .tl_lru_way_i(lru_way), .tl_hit_i(hit), .tl_miss_i(miss),
        .out_valid_o(n_out_valid), .out_ready_i(out_ready),
        .c_addr_o(n_addr), .c_rqst_byte_o(n_byte), .c_hit_way_o(n_hit_way),
        .c_lru_way_o(n_lru_way), .c_hit_o(n_hit), .c_miss_o(n_miss),
        .hit_cnt_o(n_hit_cnt), .miss_cnt_o(n_miss_cnt), .err_o(n_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [19:0] a, input logic h, input logic m);
        in_valid = v;
        addr     = a;
        hit      = h;
        miss     = m;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        kill      = 1'b0;
        out_ready = 1'b0;
        rqst_byte = 1'b0;
        hit_way   = 2'd0;
        lru_way   = 2'd0;
        drive(1'b0, 20'h0, 1'b0, 1'b0);
        do_reset();
        #1;
        check_eq("rst_out_valid", 32'(a_out_valid), 32'd0);
        check_eq("rst_c_addr", 32'(a_addr), 32'd0);
        check_eq("rst_in_ready", 32'(a_in_ready), 32'd1);
        check_eq("rst_hit_cnt", 32'(a_hit_cnt), 32'd0);
        check_eq("rst_err", 32'(a_err), 32'd0);

        // single request
        out_ready = 1'b1;
        hit_way   = 2'd2;
        lru_way   = 2'd1;
        rqst_byte = 1'b1;
        drive(1'b1, 20'h12345, 1'b1, 1'b0);
        step();
        drive(1'b0, 20'h0, 1'b0, 1'b0);
        rqst_byte = 1'b0;
        hit_way   = 2'd0;
        lru_way   = 2'd0;
        check_eq("single_valid", 32'(a_out_valid), 32'd1);
        check_eq("single_addr", 32'(a_addr), 32'h12345);
        check_eq("single_hit_way", 32'(a_hit_way), 32'd2);
        check_eq("single_lru_way", 32'(a_lru_way), 32'd1);
        check_eq("single_byte", 32'(a_byte), 32'd1);
        step();
        check_eq("single_hit_cnt", 32'(a_hit_cnt), 32'd1);
        check_eq("single_drained", 32'(a_out_valid), 32'd0);

        // backpressure into the skid entry
        out_ready = 1'b0;
        drive(1'b1, 20'h0000A, 1'b0, 1'b0);
        step();
        drive(1'b1, 20'h0000B, 1'b0, 1'b0);
        step();
        drive(1'b0, 20'h0, 1'b0, 1'b0);
        check_eq("bp_main_addr", 32'(a_addr), 32'h0000A);
        check_eq("bp_in_ready", 32'(a_in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        check_eq("bp_second_addr", 32'(a_addr), 32'h0000B);
        check_eq("bp_second_valid", 32'(a_out_valid), 32'd1);
        check_eq("bp_ready_back", 32'(a_in_ready), 32'd1);
        step();
        check_eq("bp_empty", 32'(a_out_valid), 32'd0);

        // streaming: odd addresses are misses
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 20'(i), ~i[0], i[0]);
            step();
            check_eq($sformatf("stream_addr%0d", i), 32'(a_addr), 32'(i));
            check_eq($sformatf("stream_valid%0d", i), 32'(a_out_valid), 32'd1);
        end
        drive(1'b0, 20'h0, 1'b0, 1'b0);
        step();
        check_eq("stream_done", 32'(a_out_valid), 32'd0);
        check_eq("stream_miss_cnt", 32'(a_miss_cnt), 32'd4);
        check_eq("stream_hit_cnt", 32'(a_hit_cnt), 32'd5);
        check_eq("sat_hit_cnt", 32'(s_hit_cnt), 32'd3);
        check_eq("sat_miss_cnt", 32'(s_miss_cnt), 32'd3);

        // kill with main and skid full
        out_ready = 1'b0;
        drive(1'b1, 20'h00100, 1'b1, 1'b0);
        step();
        drive(1'b1, 20'h00101, 1'b1, 1'b0);
        step();
        check_eq("kill_pre_in_ready", 32'(a_in_ready), 32'd0);
        kill      = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 20'hABCDE, 1'b1, 1'b0);
        step();
        kill = 1'b0;
        drive(1'b0, 20'h0, 1'b0, 1'b0);
        check_eq("kill_out_valid", 32'(a_out_valid), 32'd0);
        check_eq("kill_c_addr", 32'(a_addr), 32'd0);
        check_eq("kill_in_ready", 32'(a_in_ready), 32'd1);
        check_eq("kill_hit_cnt", 32'(a_hit_cnt), 32'd5);
        check_eq("kill_miss_cnt", 32'(a_miss_cnt), 32'd4);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("kill_no_leak", 32'(a_out_valid), 32'd0);
        end

        // error flag
        drive(1'b1, 20'h00055, 1'b1, 1'b1);
        step();
        drive(1'b0, 20'h0, 1'b0, 1'b0);
        check_eq("err_set", 32'(a_err), 32'd1);
        check_eq("err_sat_set", 32'(s_err), 32'd1);
        check_eq("err_pld_hit", 32'(a_hit), 32'd1);
        check_eq("err_pld_miss", 32'(a_miss), 32'd1);
        check_eq("err_pld_addr", 32'(a_addr), 32'h00055);
        step();
        step();
        check_eq("err_sticky", 32'(a_err), 32'd1);
        check_eq("err_hit_cnt", 32'(a_hit_cnt), 32'd6);
        check_eq("err_sat_hold", 32'(s_hit_cnt), 32'd3);
        out_ready = 1'b0;
        do_reset();
        check_eq("err_cleared", 32'(a_err), 32'd0);
        check_eq("rst2_hit_cnt", 32'(a_hit_cnt), 32'd0);

        // no-skid variant
        drive(1'b1, 20'h00077, 1'b0, 1'b0);
        step();
        drive(1'b1, 20'h00078, 1'b0, 1'b0);
        #1;
        check_eq("ns_main_addr", 32'(n_addr), 32'h00077);
        check_eq("ns_in_ready_low", 32'(n_in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check_eq("ns_in_ready_comb", 32'(n_in_ready), 32'd1);
        step();
        drive(1'b0, 20'h0, 1'b0, 1'b0);
        check_eq("ns_next_addr", 32'(n_addr), 32'h00078);
        check_eq("ns_next_valid", 32'(n_out_valid), 32'd1);
        step();
        check_eq("ns_drained", 32'(n_out_valid), 32'd0);
        kill = 1'b1;
        #1;
        check_eq("ns_kill_ready", 32'(n_in_ready), 32'd0);
        kill = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_cache_pipe_reg.md
Name: tl_cache_pipe_reg

Overview:
- Parametrised, elastic pipeline register between the tag-lookup (TL) stage and the cache-access (C) stage of the data cache.
- Replaces the fixed-width stall-only latch with a valid/ready handshake, an optional 2-entry skid buffer, kill-based flush, and saturating hit/miss counters.
- Carries the request payload: address, byte flag, hit way, LRU way, hit, miss.

Parameters:
- ADDR_W, 20, width of the address field.
- WAY_W, 2, width of the hit-way and LRU-way indices.
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready_o; 0 = single register with combinational in_ready_o.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- kill_i  in  1  synchronous flush of in-flight entries.
- in_valid_i  in  1  TL stage presents a request.
- in_ready_o  out  1  block can accept a request.
- tl_addr_i  in  ADDR_W  request address.
- tl_rqst_byte_i  in  1  byte-access flag.
- tl_hit_way_i  in  WAY_W  hit way.
- tl_lru_way_i  in  WAY_W  LRU victim way.
- tl_hit_i  in  1  tag hit.
- tl_miss_i  in  1  tag miss.
- out_valid_o  out  1  C stage payload valid.
- out_ready_i  in  1  C stage accepts the payload.
- c_addr_o  out  ADDR_W  registered address.
- c_rqst_byte_o  out  1  registered byte flag.
- c_hit_way_o  out  WAY_W  registered hit way.
- c_lru_way_o  out  WAY_W  registered LRU way.
- c_hit_o  out  1  registered hit.
- c_miss_o  out  1  registered miss.
- hit_cnt_o  out  CNT_W  count of hits delivered to the C stage.
- miss_cnt_o  out  CNT_W  count of misses delivered to the C stage.
- err_o  out  1  sticky flag: hit and miss were both set on an accepted request.

Behaviour:
- Transfers: in_xfer = in_valid_i & in_ready_o; out_xfer = out_valid_o & out_ready_i.
- Reset (rst_i=1 at an edge):
  - All valid bits, payload registers, counters and err_o clear to 0.
  - out_valid_o=0, all c_* outputs=0, and in_ready_o=1 from the next cycle.
- Priority: rst_i > kill_i > normal operation.
- kill_i=1 (no reset):
  - Main and skid valid bits clear; payload registers clear to 0.
  - Any in_xfer in the same cycle is dropped; any out_xfer in the same cycle is not counted.
  - Counters and err_o are kept.
  - In SKID_EN=0, in_ready_o is forced to 0 while kill_i=1.
- Output gating: c_* outputs are the main register gated by out_valid_o; all are 0 when out_valid_o=0.
- Latency: an accepted request appears on out_valid_o/c_* the cycle after in_xfer when the main register is empty or draining.
- SKID_EN=1:
  - in_ready_o = ~skid_valid, registered (no combinational path from out_ready_i).
  - Main empty, or main draining (out_xfer) with skid empty: in_xfer loads main.
  - out_xfer with skid valid: main <= skid, skid empties; an in_xfer is impossible that cycle because in_ready_o=0.
  - in_xfer with main valid and no out_xfer: data goes to skid; in_ready_o falls the next cycle.
  - Order is preserved: skid data always follows main data.
- SKID_EN=0:
  - Skid logic is absent.
  - in_ready_o = ~main_valid | out_ready_i (combinational), subject to the kill_i forcing above.
- Simultaneous in_xfer and out_xfer with skid empty: main takes the new data; out_valid_o stays 1 with no bubble.
- Counters:
  - On out_xfer, hit_cnt_o increments if c_hit_o=1 and miss_cnt_o increments if c_miss_o=1.
  - Both saturate at all-ones and never wrap.
- err_o: set on any in_xfer with tl_hit_i=tl_miss_i=1; the payload is passed unchanged; cleared only by rst_i.
- No X propagation: with SKID_EN=1 the outputs depend only on registered state; with SKID_EN=0 only in_ready_o is combinational.

Test Plan:
- Reset then single request: rst_i 1->0; then addr=0x12345, hit=1, way=2 with out_ready_i=1.
  - Required: out_valid_o=1 one cycle later with c_addr_o=0x12345, c_hit_way_o=2.
  - Required: hit_cnt_o=1 after that transfer.
- Backpressure, SKID_EN=1: out_ready_i=0; send A, B.
  - Required: A in main, B in skid, in_ready_o=0.
  - Then out_ready_i=1: A is delivered, then B on the next cycle, and in_ready_o returns to 1.
- Streaming: in_valid_i=1 and out_ready_i=1 for 8 cycles with addr=0..7.
  - Required: outputs 0..7 on consecutive cycles with no bubbles; miss_cnt_o equals the number of misses sent.
- Kill mid-operation: main and skid both full, kill_i=1 together with in_valid_i=1, addr=0xABCDE.
  - Required next cycle: out_valid_o=0, c_addr_o=0, in_ready_o=1, counters unchanged, and 0xABCDE never appears.
- Saturation and error: CNT_W=2, deliver 5 hits.
  - Required: hit_cnt_o=3.
  - Then send hit=miss=1: err_o=1 and stays 1 until rst_i.
- SKID_EN=0 with out_ready_i=0 and main full:
  - Required: in_ready_o=0.
  - Raise out_ready_i: in_ready_o=1 in the same cycle, and the next request is delivered on the following cycle.
